// File: rtl/stopwatch_control_if.sv
// Signal bundle between the stopwatch sequencing controller and its surroundings.
// The master side is the controller; the slave side feeds the pulses and consumes the timing outputs.
interface stopwatch_control_if;
  logic [1:0] decimal_places;
  logic       start;
  logic       pause;
  logic       stop;
  logic       at_max;
  logic       tick;
  logic       clr;
  logic [1:0] resolution;
  logic       running;
  logic       pause_indicator;

  modport master (
    input  decimal_places, start, pause, stop, at_max,
    output tick, clr, resolution, running, pause_indicator
  );

  modport slave (
    output decimal_places, start, pause, stop, at_max,
    input  tick, clr, resolution, running, pause_indicator
  );
endinterface

// File: rtl/stopwatch_control.sv
// Run/pause/halt sequencer for the stopwatch datapath: owns the tick prescaler,
// counter clear, latched resolution and the pause LED (blinking once the count saturates).
module stopwatch_control #(
  parameter int MS_CYCLES  = 50000,
  parameter int BLINK_MS   = 250,
  parameter int PRESCALE_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  stopwatch_control_if.master bus
);

  localparam int BLINK_CYCLES = BLINK_MS * MS_CYCLES;
  localparam int BLINK_W      = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0]    BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [PRESCALE_W-1:0] LAST_S     = PRESCALE_W'(MS_CYCLES * 1000 - 1);
  localparam logic [PRESCALE_W-1:0] LAST_DS    = PRESCALE_W'(MS_CYCLES * 100 - 1);
  localparam logic [PRESCALE_W-1:0] LAST_CS    = PRESCALE_W'(MS_CYCLES * 10 - 1);
  localparam logic [PRESCALE_W-1:0] LAST_MS    = PRESCALE_W'(MS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, HALTED} state_t;

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d, period_last;
  logic [BLINK_W-1:0]    blink_q, blink_d;
  logic [1:0]            res_q, res_d;
  logic                  tick_q, tick_d;
  logic                  clr_q, clr_d;
  logic                  running_q, running_d;
  logic                  ind_q, ind_d;
  logic                  terminal;

  always_comb begin
    case (res_q)
      2'd0:    period_last = LAST_S;
      2'd1:    period_last = LAST_DS;
      2'd2:    period_last = LAST_CS;
      default: period_last = LAST_MS;
    endcase
  end

  assign terminal = (presc_q == period_last);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    blink_d = blink_q;
    res_d   = res_q;
    tick_d  = 1'b0;
    clr_d   = 1'b0;
    ind_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = RUNNING;
          clr_d   = 1'b1;
          res_d   = bus.decimal_places;
          presc_d = '0;
        end
      end
      RUNNING: begin
        // The prescaler advances on every RUNNING cycle, including the one a pause lands on.
        presc_d = terminal ? '0 : presc_q + 1'b1;
        if (bus.stop) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end else if (bus.pause && !bus.start) begin
          state_d = PAUSED;
          ind_d   = 1'b1;
        end else if (terminal) begin
          if (bus.at_max) begin
            state_d = HALTED;
            blink_d = '0;
            ind_d   = 1'b1;
          end else begin
            tick_d = 1'b1;
          end
        end
      end
      PAUSED: begin
        if (bus.stop) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end else if (bus.start || bus.pause) begin
          state_d = RUNNING;
        end else begin
          ind_d = 1'b1;
        end
      end
      HALTED: begin
        if (bus.stop) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end else if (blink_q == BLINK_LAST) begin
          blink_d = '0;
          ind_d   = ~ind_q;
        end else begin
          blink_d = blink_q + 1'b1;
          ind_d   = ind_q;
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUNNING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      blink_q   <= '0;
      res_q     <= 2'd0;
      tick_q    <= 1'b0;
      clr_q     <= 1'b0;
      running_q <= 1'b0;
      ind_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      blink_q   <= blink_d;
      res_q     <= res_d;
      tick_q    <= tick_d;
      clr_q     <= clr_d;
      running_q <= running_d;
      ind_q     <= ind_d;
    end
  end

  assign bus.tick            = tick_q;
  assign bus.clr             = clr_q;
  assign bus.resolution      = res_q;
  assign bus.running         = running_q;
  assign bus.pause_indicator = ind_q;

endmodule

// File: tb/tb_stopwatch_control.sv
// Self-checking bench for stopwatch_control: directed scenarios plus randomized
// pulses compared cycle by cycle against an elapsed-time reference model.
module tb_stopwatch_control;
  localparam int MS = 2;
  localparam int BLINK = 2;
  localparam int B = MS * BLINK;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_HALT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stopwatch_control_if bus();

  stopwatch_control #(.MS_CYCLES(MS), .BLINK_MS(BLINK), .PRESCALE_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests_run = 0;
  int tests_failed = 0;
  logic [1:0] dp_v = 2'd0;
  bit at_max_v = 1'b0;

  // Reference model: mode, elapsed RUNNING cycles in the current period, cycles spent halted.
  int m_mode = M_IDLE;
  int m_elapsed = 0;
  int m_age = 0;
  logic [1:0] m_res = 2'd0;
  bit m_tick, m_clr, m_running, m_ind;

  function automatic int period(input logic [1:0] r);
    int p = MS;
    for (int i = int'(r); i < 3; i++) p = p * 10;
    return p;
  endfunction

  task automatic model_step(input bit s, input bit p, input bit t, input bit a,
                            input logic [1:0] dp, input bit r);
    bit wrap;
    m_tick = 1'b0;
    m_clr = 1'b0;
    if (r) begin
      m_mode = M_IDLE;
      m_res = 2'd0;
      m_elapsed = 0;
      m_age = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (s && !t) begin
          m_mode = M_RUN; m_clr = 1'b1; m_res = dp; m_elapsed = 0;
        end
        M_RUN: begin
          m_elapsed++;
          wrap = (m_elapsed == period(m_res));
          if (wrap) m_elapsed = 0;
          if (t) begin m_mode = M_IDLE; m_clr = 1'b1; end
          else if (p && !s) m_mode = M_PAUSE;
          else if (wrap) begin
            if (a) begin m_mode = M_HALT; m_age = 0; end
            else m_tick = 1'b1;
          end
        end
        M_PAUSE: begin
          if (t) begin m_mode = M_IDLE; m_clr = 1'b1; end
          else if (s || p) m_mode = M_RUN;
        end
        default: begin
          if (t) begin m_mode = M_IDLE; m_clr = 1'b1; end
          else m_age++;
        end
      endcase
    end
    m_running = (m_mode == M_RUN);
    m_ind = (m_mode == M_PAUSE) ? 1'b1 :
            (m_mode == M_HALT) ? (((m_age / B) % 2) == 0) : 1'b0;
  endtask

  task automatic step(input bit s, input bit p, input bit t, input bit r);
    bus.start = s;
    bus.pause = p;
    bus.stop = t;
    bus.at_max = at_max_v;
    bus.decimal_places = dp_v;
    rst = r;
    model_step(s, p, t, at_max_v, dp_v, r);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    tests_run++;
    if (bus.tick !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tick: got %b expected 0", bus.tick); end
    tests_run++;
    if (bus.clr !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_clr: got %b expected 0", bus.clr); end
    tests_run++;
    if (bus.running !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_running: got %b expected 0", bus.running); end
    tests_run++;
    if (bus.pause_indicator !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ind: got %b expected 0", bus.pause_indicator); end
    tests_run++;
    if (bus.resolution !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_res: got %0d expected 0", bus.resolution); end
    step(0, 0, 0, 0);
  endtask

  task automatic test_fast_count;
    int ticks = 0;
    dp_v = 2'd3;
    step(1, 0, 0, 0);
    tests_run++;
    if ({bus.clr, bus.running, bus.tick, bus.resolution} !== {1'b1, 1'b1, 1'b0, 2'd3}) begin
      tests_failed++;
      $display("[TB] FAIL start_outputs: got clr/run/tick/res %b%b%b/%0d expected 110/3", bus.clr, bus.running, bus.tick, bus.resolution);
    end
    for (int k = 1; k <= 20; k++) begin
      step(0, 0, 0, 0);
      if (bus.tick === 1'b1) ticks++;
      tests_run++;
      if ({bus.tick, bus.clr} !== {((k % 2) == 0), 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL fast_tick_k%0d: got tick/clr %b%b expected %b0", k, bus.tick, bus.clr, ((k % 2) == 0));
      end
    end
    tests_run++;
    if (ticks != 10) begin tests_failed++; $display("[TB] FAIL fast_tick_count: got %0d expected 10", ticks); end
  endtask

  task automatic test_resolution_latch;
    int first = 0;
    int ticks = 0;
    step(0, 0, 1, 0);
    tests_run++;
    if ({bus.clr, bus.running} !== 2'b10) begin
      tests_failed++; $display("[TB] FAIL stop_clr: got clr/run %b%b expected 10", bus.clr, bus.running);
    end
    dp_v = 2'd1;
    step(1, 0, 0, 0);
    dp_v = 2'd3;
    for (int k = 1; k <= 220; k++) begin
      step(0, 0, 0, 0);
      if (bus.tick === 1'b1) begin ticks++; if (first == 0) first = k; end
    end
    tests_run++;
    if (first != 200 || ticks != 1) begin
      tests_failed++; $display("[TB] FAIL latched_period: got first %0d count %0d expected 200 1", first, ticks);
    end
    tests_run++;
    if (bus.resolution !== 2'd1) begin tests_failed++; $display("[TB] FAIL latched_res: got %0d expected 1", bus.resolution); end
    step(0, 0, 1, 0);
    tests_run++;
    if (bus.clr !== 1'b1) begin tests_failed++; $display("[TB] FAIL stop_clr2: got %b expected 1", bus.clr); end
    step(1, 0, 0, 0);
    first = 0;
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 0);
      if (bus.tick === 1'b1 && first == 0) first = k;
    end
    tests_run++;
    if (first != 2 || bus.resolution !== 2'd3) begin
      tests_failed++; $display("[TB] FAIL restart_period: got first %0d res %0d expected 2 3", first, bus.resolution);
    end
  endtask

  task automatic test_pause_resume;
    int first = 0;
    int bad = 0;
    step(0, 0, 1, 0);
    dp_v = 2'd2;
    step(1, 0, 0, 0);
    for (int k = 1; k <= 6; k++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    tests_run++;
    if ({bus.running, bus.pause_indicator} !== 2'b01) begin
      tests_failed++; $display("[TB] FAIL pause_enter: got run/ind %b%b expected 01", bus.running, bus.pause_indicator);
    end
    for (int k = 1; k <= 50; k++) begin
      step(0, 0, 0, 0);
      if ({bus.running, bus.pause_indicator, bus.tick} !== 3'b010) bad++;
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("[TB] FAIL pause_hold: got %0d bad cycles expected 0", bad); end
    step(1, 0, 0, 0);
    tests_run++;
    if ({bus.running, bus.pause_indicator} !== 2'b10) begin
      tests_failed++; $display("[TB] FAIL resume: got run/ind %b%b expected 10", bus.running, bus.pause_indicator);
    end
    bad = 0;
    for (int k = 1; k <= 20; k++) begin
      step(0, 0, 0, 0);
      if (bus.tick === 1'b1 && first == 0) first = k;
      if (bus.pause_indicator !== 1'b0) bad++;
    end
    tests_run++;
    if (first != 13 || bad != 0) begin
      tests_failed++; $display("[TB] FAIL resume_tick: got first %0d ind_bad %0d expected 13 0", first, bad);
    end
  endtask

  task automatic test_halt;
    step(0, 0, 1, 0);
    dp_v = 2'd3;
    at_max_v = 1'b1;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    tests_run++;
    if ({bus.tick, bus.running, bus.pause_indicator} !== 3'b001) begin
      tests_failed++; $display("[TB] FAIL halt_enter: got tick/run/ind %b%b%b expected 001", bus.tick, bus.running, bus.pause_indicator);
    end
    for (int k = 1; k <= 16; k++) begin
      step((k % 2) == 1, (k % 5) == 0, 0, 0);
      tests_run++;
      if ({bus.pause_indicator, bus.running, bus.tick} !== {(((k / 4) % 2) == 0), 2'b00}) begin
        tests_failed++;
        $display("[TB] FAIL halt_blink_k%0d: got ind/run/tick %b%b%b expected %b00", k, bus.pause_indicator, bus.running, bus.tick, (((k / 4) % 2) == 0));
      end
    end
    step(0, 0, 1, 0);
    tests_run++;
    if ({bus.clr, bus.running, bus.pause_indicator} !== 3'b100) begin
      tests_failed++; $display("[TB] FAIL halt_stop: got clr/run/ind %b%b%b expected 100", bus.clr, bus.running, bus.pause_indicator);
    end
    at_max_v = 1'b0;
  endtask

  task automatic test_coincide;
    step(0, 0, 1, 0);
    dp_v = 2'd3;
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 1, 0);
    tests_run++;
    if ({bus.clr, bus.running, bus.pause_indicator} !== 3'b100) begin
      tests_failed++; $display("[TB] FAIL start_stop_paused: got clr/run/ind %b%b%b expected 100", bus.clr, bus.running, bus.pause_indicator);
    end
    step(1, 1, 0, 0);
    tests_run++;
    if ({bus.clr, bus.running} !== 2'b11) begin
      tests_failed++; $display("[TB] FAIL start_pause_idle: got clr/run %b%b expected 11", bus.clr, bus.running);
    end
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    tests_run++;
    if ({bus.tick, bus.clr} !== 2'b01) begin
      tests_failed++; $display("[TB] FAIL terminal_stop: got tick/clr %b%b expected 01", bus.tick, bus.clr);
    end
  endtask

  task automatic test_reset_mid;
    dp_v = 2'd3;
    step(1, 0, 0, 0);
    for (int k = 1; k <= 3; k++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    tests_run++;
    if ({bus.tick, bus.clr, bus.running, bus.pause_indicator, bus.resolution} !== 6'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid: got tick/clr/run/ind/res %b%b%b%b/%0d expected 0000/0", bus.tick, bus.clr, bus.running, bus.pause_indicator, bus.resolution);
    end
    step(0, 0, 0, 0);
    tests_run++;
    if ({bus.clr, bus.running, bus.tick} !== 3'b000) begin
      tests_failed++; $display("[TB] FAIL reset_release: got clr/run/tick %b%b%b expected 000", bus.clr, bus.running, bus.tick);
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 3000; k++) begin
      dp_v = 2'($urandom_range(0, 3));
      at_max_v = ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 499) == 0);
      tests_run++;
      if ({bus.tick, bus.clr, bus.running, bus.pause_indicator, bus.resolution} !==
          {m_tick, m_clr, m_running, m_ind, m_res}) begin
        tests_failed++;
        $display("[TB] FAIL random_c%0d: got tick/clr/run/ind/res %b%b%b%b/%0d expected %b%b%b%b/%0d",
                 k, bus.tick, bus.clr, bus.running, bus.pause_indicator, bus.resolution,
                 m_tick, m_clr, m_running, m_ind, m_res);
      end
      tests_run++;
      if ((bus.tick & bus.clr) !== 1'b0) begin
        tests_failed++; $display("[TB] FAIL random_tick_clr_c%0d: got both high expected exclusive", k);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_fast_count();
    test_resolution_latch();
    test_pause_resume();
    test_halt();
    test_coincide();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/stopwatch_control.md
# stopwatch_control

Sequencing controller for the stopwatch counting datapath. It sits between the edge-detected start/pause/stop pulses and the BCD time counter. It owns the run/pause/halt state machine, the resolution-dependent tick prescaler, counter clear, and the pause-indicator drive, including a blink pattern when the counter saturates. The datapath only counts on `tick` and clears on `clr`; all timing decisions live here.

## Interface
- `MS_CYCLES`, default 50000: clock cycles per millisecond, must be ≥ 1.
- `BLINK_MS`, default 250: half-period of the saturation blink in milliseconds, must be ≥ 1.
- `PRESCALE_W`, default 32: prescaler width; must hold `MS_CYCLES*1000-1`.
- `clk`, input, 1: single clock; all logic on rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `decimal_places`, input, 2: requested resolution; 0 = 1 s, 1 = 0.1 s, 2 = 0.01 s, 3 = 0.001 s.
- `start`, input, 1: one-cycle pulse (already edge-detected).
- `pause`, input, 1: one-cycle pulse.
- `stop`, input, 1: one-cycle pulse.
- `at_max`, input, 1: datapath count is at its maximum displayable value.
- `tick`, output, 1: one-cycle pulse; datapath increments by one LSB at the current resolution.
- `clr`, output, 1: one-cycle pulse; datapath clears to zero.
- `resolution`, output, 2: latched `decimal_places` used by the datapath for the decimal point and digit selection.
- `running`, output, 1: high in RUNNING.
- `pause_indicator`, output, 1: LED drive.

## Operation
- States: IDLE, RUNNING, PAUSED, HALTED.
- Period P by latched resolution: 0 → `MS_CYCLES*1000`; 1 → `*100`; 2 → `*10`; 3 → `*1`.
- Event priority when pulses coincide: stop > start > pause.
- IDLE:
  - start → RUNNING. Pulse `clr`, latch `decimal_places` into `resolution`, zero the prescaler.
  - stop and pause are ignored; no `clr` is issued.
- RUNNING:
  - The prescaler increments every cycle. At P-1 it wraps to 0 and sets the terminal condition.
  - On the terminal condition with `at_max`=0: pulse `tick`.
  - On the terminal condition with `at_max`=1: no tick; go to HALTED.
  - pause → PAUSED. The prescaler holds its value, so the partial period is preserved on resume.
  - stop → IDLE with `clr`.
  - start is ignored.
- PAUSED:
  - start or pause → RUNNING. The prescaler resumes from its held value.
  - stop → IDLE with `clr`.
- HALTED:
  - Only stop is accepted, → IDLE with `clr`. start and pause are ignored.
- `decimal_places` changes outside the IDLE→RUNNING transition have no effect.
- pause_indicator:
  - 0 in IDLE and RUNNING, 1 in PAUSED.
  - In HALTED it is 1 on entry and toggles every `BLINK_MS*MS_CYCLES` cycles. The blink counter is zeroed on entry.
- A terminal count coinciding with stop or pause:
  - stop wins: no tick, `clr` issued.
  - pause wins: no tick; the prescaler holds at 0 after the wrap.

## Timing
- All outputs are registered.
- Reset: state IDLE, `tick`=0, `clr`=0, `resolution`=0, `running`=0, `pause_indicator`=0, prescaler and blink counter 0.
- Event pulse sampled at edge N: new state, `clr`, and `running` are visible in cycle N+1. `clr` is high for exactly one cycle.
- Start at edge N: `tick` is first high in cycle N+P, then every P cycles while RUNNING.
- Pause/resume: total RUNNING cycles between ticks always equals P.
- `rst` mid-operation overrides everything in the next cycle; `clr` is not pulsed by reset.
- `tick` and `clr` are never high in the same cycle.

## Test plan
- MS_CYCLES=2, dp=3: reset, then start → `clr` one cycle, `running`=1, ticks every 2 cycles; 10 ticks in 20 cycles.
- MS_CYCLES=2, dp=1: change dp to 3 while running → period stays 200 cycles. stop → `clr`. restart → period 2.
- dp=2 (P=20): pause 7 cycles after start, hold 50 cycles, resume → next tick exactly 13 RUNNING cycles later; `pause_indicator`=1 only while paused.
- `at_max` held high: at the terminal count there is no tick, HALTED is entered; with BLINK_MS=2 and MS_CYCLES=2 the indicator toggles every 4 cycles. start is ignored; stop → `clr`, IDLE, indicator 0.
- start+stop in the same cycle from PAUSED → IDLE with `clr`. start+pause from IDLE → RUNNING.
- Assert `rst` mid-RUNNING → next cycle all outputs 0, IDLE, no `clr` pulse.
